// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one result bit per cycle, LSB first, valid/ready on both sides.
// Optional macro SERIAL_ADD_SUB_OVF_EN adds the o_overflow port (signed overflow flag).
module serial_add_sub #(
  parameter int unsigned DATA_WD = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_WD-1:0] i_a,
  input  logic [DATA_WD-1:0] i_b,
  input  logic               i_sub,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_WD:0]   o_arith_out
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic               o_overflow
`endif
);

  if (DATA_WD < 2 || DATA_WD > 32) begin : g_bad_width
    $error("serial_add_sub: DATA_WD must be in 2..32");
  end

  localparam int unsigned CNT_WD = $clog2(DATA_WD + 1);
  localparam logic [CNT_WD-1:0] CNT_FINAL = CNT_WD'(DATA_WD);
  localparam logic [CNT_WD-1:0] CNT_MSB   = CNT_WD'(DATA_WD - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [DATA_WD-1:0] a_q, a_d;
  logic [DATA_WD-1:0] b_q, b_d;
  logic [DATA_WD-1:0] sum_q, sum_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d;
  logic [DATA_WD:0]   out_q, out_d;

  logic b_eff;
  logic bit_sum;
  logic carry_gen;

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic cmsb_q, cmsb_d;
  logic ovf_q, ovf_d;
`endif

  // Operands shift right each CALC cycle so bit 0 is always the active bit.
  always_comb begin
    b_eff     = b_q[0] ^ sub_q;
    bit_sum   = a_q[0] ^ b_eff ^ carry_q;
    carry_gen = (a_q[0] & b_eff) | (carry_q & (a_q[0] ^ b_eff));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    cmsb_d  = cmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          sub_d   = i_sub;
          cnt_d   = '0;
          carry_d = i_sub;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_FINAL) begin
          // Extra cycle after the last bit publishes the result; MSB is borrow for subtract.
          out_d   = {carry_q ^ sub_q, sum_q};
`ifdef SERIAL_ADD_SUB_OVF_EN
          ovf_d   = cmsb_q ^ carry_q;
`endif
          state_d = DONE;
        end else begin
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          sum_d   = {bit_sum, sum_q[DATA_WD-1:1]};
          carry_d = carry_gen;
          cnt_d   = cnt_q + CNT_WD'(1);
`ifdef SERIAL_ADD_SUB_OVF_EN
          if (cnt_q == CNT_MSB) begin
            cmsb_d = carry_q;
          end
`endif
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      cmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
      cmsb_q  <= cmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_arith_out = out_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
  assign o_overflow  = ovf_q;
`endif

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter DATA_WD, default 4, SHALL set the operand width; legal values are 2 to 32.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port i_clk, input, 1 bit: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit: SHALL be the asynchronous active-low reset.
REQ-005 Port i_valid, input, 1 bit: SHALL flag that the request operands are valid.
REQ-006 Port o_ready, output, 1 bit: SHALL flag that a request can be accepted.
REQ-007 Port i_a, input, DATA_WD bits: SHALL be the minuend or first addend.
REQ-008 Port i_b, input, DATA_WD bits: SHALL be the subtrahend or second addend.
REQ-009 Port i_sub, input, 1 bit: SHALL select the operation: 0 = add, 1 = subtract.
REQ-010 Port o_valid, output, 1 bit: SHALL flag that the result is valid.
REQ-011 Port i_ready, input, 1 bit: SHALL flag that the consumer accepts the result.
REQ-012 Port o_arith_out, output, DATA_WD+1 bits: SHALL carry the result, with MSB = carry (add) or borrow (sub).

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, when i_valid=1, the block SHALL register i_a, i_b and i_sub, clear the bit counter, set the internal carry to i_sub and enter CALC.
REQ-016 In IDLE with i_valid=0, all inputs SHALL be ignored and the state SHALL be held.
REQ-017 In CALC, each cycle SHALL compute one result bit k, LSB first, as a[k] XOR b'[k] XOR carry (b' = b for add, ~b for sub), update the carry, and increment k.
REQ-018 After exactly DATA_WD CALC cycles, the FSM SHALL enter DONE; o_valid SHALL rise DATA_WD+1 edges after the accepting edge.
REQ-019 In DONE, o_arith_out[DATA_WD-1:0] SHALL hold the sum or difference modulo 2^DATA_WD.
REQ-020 In DONE, o_arith_out[DATA_WD] SHALL hold the final carry for add, or the inverted final carry (borrow) for sub.
REQ-021 In DONE, o_arith_out and o_valid SHALL stay stable until i_ready=1.
REQ-022 In DONE with i_ready=1, the FSM SHALL return to IDLE; o_ready SHALL be 1 in the next cycle, giving no back-to-back accept within the same cycle.
REQ-023 Changes to i_a, i_b or i_sub after acceptance SHALL NOT affect the result in flight.
REQ-024 o_arith_out SHALL hold its last value outside DONE; it is don't-care to consumers.

Reset
REQ-025 Assertion of i_rst_n=0 SHALL force IDLE, o_ready=1 after release, o_valid=0, o_arith_out=0, and clear the counter and carry, at any time including mid-CALC or in DONE.
REQ-026 A reset during CALC SHALL discard the operation with no result produced.

Configuration
REQ-027 With macro SERIAL_ADD_SUB_OVF_EN defined, the block SHALL add output port o_overflow (1 bit) that is valid in DONE.
REQ-028 o_overflow SHALL equal the carry into the MSB XOR the carry out of the MSB, signalling two's-complement signed overflow, and SHALL reset to 0.
REQ-029 Without SERIAL_ADD_SUB_OVF_EN, the port SHALL be absent and the signed-overflow logic SHALL not be present.

Verification (DATA_WD=4)
REQ-030 Add 5+3, i_sub=0 -> o_valid 5 edges after accept, o_arith_out=5'b0_1000, o_overflow=1.
REQ-031 Add 15+1 -> o_arith_out=5'b1_0000 (carry=1), o_overflow=0.
REQ-032 Subtract 5-3 -> o_arith_out=5'b0_0010; subtract 3-5 -> o_arith_out=5'b1_1110 (borrow=1).
REQ-033 Subtract 8-1 (signed -8 minus 1) -> o_arith_out=5'b0_0111, o_overflow=1.
REQ-034 Hold i_ready=0 for 3 cycles in DONE while toggling i_a -> result stable, o_ready=0; then i_ready=1 -> IDLE next cycle.
REQ-035 Assert i_rst_n=0 at CALC bit 2 -> o_valid=0, o_arith_out=0; a new request after release computes correctly.
